fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the instruction memory.
//  Holds the PC and drives it as the memory's word read address. Captures the returned instruction into an IF/ID register.
//  Applies stall, branch and jump redirects from the decode stage, and counts fetched instructions.
// PARAMETERS
//  ADDR_W   5   PC / readAddress width in words (PC wraps mod 2^ADDR_W)
//  MEM_SIZE 8   instruction-memory depth in words (used only by the bounds check)
//  RESET_PC 0   PC value loaded on reset
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high reset
//  stall         in   1       hold PC and IF/ID (load-use hazard)
//  jump          in   1       redirect to jumpTarget
//  jumpTarget    in   26      J-format target field; low ADDR_W bits used
//  branchTaken   in   1       redirect to branch target
//  branchOffset  in   16      signed I-format offset in words; low ADDR_W bits used
//  instrIn       in   32      instruction from memory for readAddress (combinational read)
//  readAddress   out  ADDR_W  current PC, driven directly from the PC register
//  ifIdInstr     out  32      latched instruction
//  ifIdPc        out  ADDR_W  PC of ifIdInstr
//  ifIdValid     out  1       ifIdInstr is real (0 = bubble)
//  fetchCount    out  16      valid fetches since reset, saturating at 16'hFFFF
//  pcFault       out  1       PC left instruction memory (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any time, including mid-redirect):
//    - pc=RESET_PC, ifIdInstr=0, ifIdPc=0, ifIdValid=0, fetchCount=0, pcFault=0.
//    - Clears on assertion, without waiting for a clock edge.
//  - readAddress = pc with no added delay; instrIn is sampled at the same edge that advances pc.
//  - Edge priority, highest first: stall > jump > branchTaken > sequential.
//  - stall=1:
//    - pc, ifIdInstr, ifIdPc, ifIdValid and fetchCount hold.
//    - jump or branchTaken raised in the same cycle is ignored.
//    - The source keeps the redirect asserted until stall drops.
//  - jump=1:
//    - pc <= jumpTarget[ADDR_W-1:0].
//    - ifIdInstr <= 0, ifIdValid <= 0 (flush the wrong-path fetch).
//    - ifIdPc holds; fetchCount holds.
//  - branchTaken=1 (jump=0):
//    - pc <= ifIdPc + 1 + branchOffset[ADDR_W-1:0], truncated mod 2^ADDR_W.
//    - Flush exactly as for jump.
//  - Sequential:
//    - ifIdInstr <= instrIn, ifIdPc <= pc, ifIdValid <= 1.
//    - pc <= pc + 1 mod 2^ADDR_W (31 -> 0 at ADDR_W=5).
//    - fetchCount += 1, saturating at 16'hFFFF.
//  - A redirect takes effect in 1 cycle: the new pc appears on readAddress the cycle after it is asserted.
//  - One wrong-path instruction is always squashed, giving a single bubble.
//  - All arithmetic is unsigned ADDR_W-bit; negative offsets wrap naturally.
// CONFIGURATION
//  - PC_BOUNDS_CHECK_EN defined:
//    - On a sequential fetch edge with pc >= MEM_SIZE, instead of a normal fetch: pcFault <= 1 (sticky); pc holds;
//      ifIdValid <= 0; ifIdInstr <= 0; fetchCount holds.
//    - While pcFault=1, every edge behaves the same way.
//    - jump, branchTaken and stall are ignored while faulted; only reset clears pcFault.
//    - A redirect target >= MEM_SIZE is accepted and faults on the following edge.
//  - PC_BOUNDS_CHECK_EN undefined:
//    - pcFault is tied to 0 and out-of-range addresses are fetched normally.
//    - Out-of-range fetches return 0, i.e. a nop.
// TESTING
//  1. reset pulse with no clock edge -> readAddress=0, ifIdValid=0, fetchCount=0 immediately;
//     after 3 free-running edges -> readAddress=3, ifIdPc=2, fetchCount=3.
//  2. stall=1 for 2 cycles at pc=4 -> readAddress stays 4 and ifIdInstr unchanged;
//     jump=1 held during the stall is ignored.
//  3. jump=1, jumpTarget=0 at pc=6 -> next edge: readAddress=0, ifIdValid=0, fetchCount unchanged;
//     following edge: ifIdInstr=instr[0], ifIdValid=1.
//  4. ifIdPc=1, branchTaken=1, branchOffset=16'h0001 -> pc=3, one bubble;
//     branchOffset=16'hFFFD with ifIdPc=1 -> pc=31 (wrap).
//  5. jump and branchTaken asserted together, jumpTarget=5, branchOffset=2 -> pc=5 (jump wins).
//  6. PC_BOUNDS_CHECK_EN, MEM_SIZE=8, free-run from pc=7 ->
//     after the fetch edge at pc=8: pcFault=1, readAddress stuck at 8, ifIdValid=0;
//     jump to 0 is ignored; reset clears the fault.
//     Undefined build, same run: pcFault=0 and pc advances to 9.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, IF/ID latch, redirects, fetch counter.
// Optional PC bounds fault is enabled by defining PC_BOUNDS_CHECK_EN.
module fetch_pc_unit #(
  parameter int ADDR_W   = 5,
  parameter int MEM_SIZE = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic [25:0]       jumpTarget,
  input  logic              branchTaken,
  input  logic [15:0]       branchOffset,
  input  logic [31:0]       instrIn,
  output logic [ADDR_W-1:0] readAddress,
  output logic [31:0]       ifIdInstr,
  output logic [ADDR_W-1:0] ifIdPc,
  output logic              ifIdValid,
  output logic [15:0]       fetchCount,
  output logic              pcFault
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ifpc_d;
  logic [31:0]       instr_d;
  logic              vld_d;
  logic [15:0]       cnt_d;
  logic              flt;
  logic              flt_d;
  logic              seq_req;
  logic              go_flt;
  logic              go_stl;
  logic              go_jmp;
  logic              go_br;
  logic              go_seq;

  logic unused_hi;
  assign unused_hi = ^{jumpTarget[25:ADDR_W],
                       branchOffset[15:ADDR_W]};

  assign seq_req = !stall && !jump && !branchTaken;

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_SIZE);
  logic oob;
  assign oob    = {1'b0, pc} >= MEM_LIM;
  // Once faulted every edge is a fault edge until reset.
  assign go_flt = flt || (seq_req && oob);
`else
  localparam int unused_mem = MEM_SIZE;
  assign go_flt = 1'b0;
`endif

  assign go_stl = !go_flt && stall;
  assign go_jmp = !go_flt && !stall && jump;
  assign go_br  = !go_flt && !stall && !jump && branchTaken;
  assign go_seq = !go_flt && seq_req;

  always_comb begin
    pc_d    = pc;
    ifpc_d  = ifIdPc;
    instr_d = ifIdInstr;
    vld_d   = ifIdValid;
    cnt_d   = fetchCount;
    flt_d   = flt;
    unique case (1'b1)
      go_flt: begin
        instr_d = '0;
        vld_d   = 1'b0;
        flt_d   = 1'b1;
      end
      go_stl: ;
      go_jmp: begin
        pc_d    = jumpTarget[ADDR_W-1:0];
        instr_d = '0;
        vld_d   = 1'b0;
      end
      go_br: begin
        pc_d    = ifIdPc + ADDR_W'(1)
                + branchOffset[ADDR_W-1:0];
        instr_d = '0;
        vld_d   = 1'b0;
      end
      go_seq: begin
        pc_d    = pc + ADDR_W'(1);
        ifpc_d  = pc;
        instr_d = instrIn;
        vld_d   = 1'b1;
        if (fetchCount != 16'hFFFF)
          cnt_d = fetchCount + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= ADDR_W'(RESET_PC);
      ifIdPc     <= '0;
      ifIdInstr  <= '0;
      ifIdValid  <= 1'b0;
      fetchCount <= '0;
      flt        <= 1'b0;
    end else begin
      pc         <= pc_d;
      ifIdPc     <= ifpc_d;
      ifIdInstr  <= instr_d;
      ifIdValid  <= vld_d;
      fetchCount <= cnt_d;
      flt        <= flt_d;
    end
  end

  assign readAddress = pc;

`ifdef PC_BOUNDS_CHECK_EN
  assign pcFault = flt;
`else
  assign pcFault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: reference model plus directed redirect scenarios.
// Tracks PC_BOUNDS_CHECK_EN to match the build under test.
module tb_fetch_pc_unit;

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam int AW  = 5;
  localparam int MS  = 8;
  localparam int MOD = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          jump = 1'b0;
  logic [25:0]   jumpTarget = '0;
  logic          branchTaken = 1'b0;
  logic [15:0]   branchOffset = '0;
  logic [31:0]   instrIn;
  logic [AW-1:0] readAddress;
  logic [31:0]   ifIdInstr;
  logic [AW-1:0] ifIdPc;
  logic          ifIdValid;
  logic [15:0]   fetchCount;
  logic          pcFault;

  fetch_pc_unit #(.ADDR_W(AW), .MEM_SIZE(MS), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .jump(jump),
    .jumpTarget(jumpTarget), .branchTaken(branchTaken),
    .branchOffset(branchOffset), .instrIn(instrIn),
    .readAddress(readAddress), .ifIdInstr(ifIdInstr),
    .ifIdPc(ifIdPc), .ifIdValid(ifIdValid),
    .fetchCount(fetchCount), .pcFault(pcFault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input int a);
    return (a < MS) ? 32'h1100_0000 + 32'(a) : 32'h0;
  endfunction

  assign instrIn = mem(int'(readAddress));

  int vectors = 0;
  int errs = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int m_pc, m_ipc, m_cnt;
  logic [31:0] m_ins;
  bit m_vld, m_flt;

  // Reference: what each edge must do, by the priority rules.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc = 0; m_ipc = 0; m_ins = 0;
      m_vld = 0; m_cnt = 0; m_flt = 0;
    end else if (BC && (m_flt ||
               (!stall && !jump && !branchTaken && m_pc >= MS))) begin
      m_flt = 1; m_vld = 0; m_ins = 0;
    end else if (stall) begin
    end else if (jump) begin
      m_pc = int'(jumpTarget) % MOD; m_vld = 0; m_ins = 0;
    end else if (branchTaken) begin
      m_pc = (m_ipc + 1 + int'(branchOffset) % MOD) % MOD;
      m_vld = 0; m_ins = 0;
    end else begin
      m_ins = mem(m_pc); m_ipc = m_pc; m_vld = 1;
      m_pc = (m_pc + 1) % MOD;
      if (m_cnt < 65535) m_cnt++;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("m.readAddress", 32'(readAddress), 32'(m_pc));
      chk("m.ifIdInstr", ifIdInstr, m_ins);
      chk("m.ifIdPc", 32'(ifIdPc), 32'(m_ipc));
      chk("m.ifIdValid", 32'(ifIdValid), 32'(m_vld));
      chk("m.fetchCount", 32'(fetchCount), 32'(m_cnt));
      chk("m.pcFault", 32'(pcFault), 32'(m_flt));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 armed = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);

    // 1: asynchronous reset between edges, then free run
    reset = 1'b1;
    #1;
    chk("t1.rst.ra", 32'(readAddress), 32'd0);
    chk("t1.rst.vld", 32'(ifIdValid), 32'd0);
    chk("t1.rst.cnt", 32'(fetchCount), 32'd0);
    #1 reset = 1'b0;
    tick(3);
    chk("t1.run.ra", 32'(readAddress), 32'd3);
    chk("t1.run.ipc", 32'(ifIdPc), 32'd2);
    chk("t1.run.cnt", 32'(fetchCount), 32'd3);

    // 2: stall at pc=4 with a jump held
    tick(1);
    chk("t2.pre.ra", 32'(readAddress), 32'd4);
    stall = 1'b1; jump = 1'b1; jumpTarget = 26'd20;
    tick(2);
    chk("t2.ra", 32'(readAddress), 32'd4);
    chk("t2.ins", ifIdInstr, 32'h1100_0003);
    chk("t2.cnt", 32'(fetchCount), 32'd4);
    stall = 1'b0; jump = 1'b0;
    tick(2);

    // 3: jump to 0 from pc=6
    chk("t3.pre.ra", 32'(readAddress), 32'd6);
    jump = 1'b1; jumpTarget = 26'd0;
    tick(1);
    jump = 1'b0;
    chk("t3.ra", 32'(readAddress), 32'd0);
    chk("t3.vld", 32'(ifIdValid), 32'd0);
    chk("t3.cnt", 32'(fetchCount), 32'd6);
    tick(1);
    chk("t3.ins", ifIdInstr, 32'h1100_0000);
    chk("t3.vld2", 32'(ifIdValid), 32'd1);
    chk("t3.cnt2", 32'(fetchCount), 32'd7);
    tick(1);

    // 4: branches, including a negative offset that wraps
    chk("t4.pre.ipc", 32'(ifIdPc), 32'd1);
    branchTaken = 1'b1; branchOffset = 16'h0001;
    tick(1);
    branchTaken = 1'b0;
    chk("t4.ra", 32'(readAddress), 32'd3);
    chk("t4.vld", 32'(ifIdValid), 32'd0);
    jump = 1'b1; jumpTarget = 26'd1;
    tick(1);
    jump = 1'b0;
    tick(1);
    chk("t4.pre2.ipc", 32'(ifIdPc), 32'd1);
    branchTaken = 1'b1; branchOffset = 16'hFFFD;
    tick(1);
    branchTaken = 1'b0;
    chk("t4.wrap.ra", 32'(readAddress), 32'd31);
`ifndef PC_BOUNDS_CHECK_EN
    tick(1);
    chk("t4.seq.ra", 32'(readAddress), 32'd0);
    chk("t4.seq.ins", ifIdInstr, 32'h0);
    chk("t4.seq.vld", 32'(ifIdValid), 32'd1);
`endif

    // 5: jump beats branch
    jump = 1'b1; branchTaken = 1'b1;
    jumpTarget = 26'd5; branchOffset = 16'd2;
    tick(1);
    jump = 1'b0; branchTaken = 1'b0;
    chk("t5.ra", 32'(readAddress), 32'd5);

    // 6: run past the end of instruction memory
    jump = 1'b1; jumpTarget = 26'd7;
    tick(1);
    jump = 1'b0;
    tick(1);
    chk("t6.ra8", 32'(readAddress), 32'd8);
    chk("t6.ipc7", 32'(ifIdPc), 32'd7);
    tick(1);
`ifdef PC_BOUNDS_CHECK_EN
    chk("t6.flt", 32'(pcFault), 32'd1);
    chk("t6.stuck", 32'(readAddress), 32'd8);
    chk("t6.vld", 32'(ifIdValid), 32'd0);
    jump = 1'b1; jumpTarget = 26'd0;
    tick(1);
    jump = 1'b0;
    chk("t6.jmp.ra", 32'(readAddress), 32'd8);
    chk("t6.jmp.flt", 32'(pcFault), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6.rst.flt", 32'(pcFault), 32'd0);
    chk("t6.rst.ra", 32'(readAddress), 32'd0);
    #1 reset = 1'b0;
`else
    chk("t6.noflt", 32'(pcFault), 32'd0);
    chk("t6.ra9", 32'(readAddress), 32'd9);
    chk("t6.nop", ifIdInstr, 32'h0);
`endif
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
